// File: rtl/score_event_arbiter.sv
// Arbitrates diamond/gift/hazard scoring events onto a 2-digit BCD score, one unit per clock.
// Define SCORE_FRAME_GATE_EN to limit each source to one accepted event per frame.
module score_event_arbiter #(
    parameter int unsigned DIAMOND_PTS  = 1,
    parameter int unsigned GIFT_PTS     = 5,
    parameter int unsigned PENALTY_PTS  = 3,
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       diamond_hit_i,
    input  logic       gift_hit_i,
    input  logic       hazard_hit_i,
    input  logic       start_of_frame_i,
    output logic [3:0] score_ones_o,
    output logic [3:0] score_tens_o,
    output logic       level_up_o,
    output logic       busy_o,
    output logic       win_o
);

    typedef enum logic [1:0] {StBlank, StIdle, StStep, StWin} state_e;

    state_e     state_q, state_d;
    logic [2:0] hit_q, rise, accept, grant;
    logic [2:0] pending_q, pending_d;
    logic [3:0] blank_cnt_q, blank_cnt_d;
    logic [3:0] units_q, units_d;
    logic [3:0] ones_q, ones_d, tens_q, tens_d;
    logic       sub_q, sub_d;
    logic       level_up_q, level_up_d;
    logic       win_q, win_d;
    logic       accepting;

    // Bit order throughout: {hazard, gift, diamond}
    assign rise      = {hazard_hit_i, gift_hit_i, diamond_hit_i} & ~hit_q;
    assign accepting = (state_q == StIdle) || (state_q == StStep);

`ifdef SCORE_FRAME_GATE_EN
    logic [2:0] used_q, used_d;

    // A frame strobe coinciding with an event still lets that event in.
    assign accept = accepting ? (rise & (~used_q | {3{start_of_frame_i}})) : 3'b000;
    assign used_d = (used_q & ~{3{start_of_frame_i}}) | accept;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) used_q <= 3'b000;
        else         used_q <= used_d;
    end
`else
    logic unused_sof;

    assign unused_sof = start_of_frame_i;
    assign accept     = accepting ? rise : 3'b000;
`endif

    always_comb begin
        grant = 3'b000;
        if (state_q == StIdle) begin
            if (pending_q[2])      grant = 3'b100;
            else if (pending_q[1]) grant = 3'b010;
            else if (pending_q[0]) grant = 3'b001;
        end
    end

    assign pending_d = accepting ? ((pending_q & ~grant) | accept) : 3'b000;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= StBlank;
            hit_q       <= 3'b000;
            pending_q   <= 3'b000;
            blank_cnt_q <= 4'd0;
            units_q     <= 4'd0;
            ones_q      <= 4'd0;
            tens_q      <= 4'd0;
            sub_q       <= 1'b0;
            level_up_q  <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hit_q       <= {hazard_hit_i, gift_hit_i, diamond_hit_i};
            pending_q   <= pending_d;
            blank_cnt_q <= blank_cnt_d;
            units_q     <= units_d;
            ones_q      <= ones_d;
            tens_q      <= tens_d;
            sub_q       <= sub_d;
            level_up_q  <= level_up_d;
            win_q       <= win_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        blank_cnt_d = blank_cnt_q;
        units_d     = units_q;
        sub_d       = sub_q;
        ones_d      = ones_q;
        tens_d      = tens_q;
        level_up_d  = 1'b0;
        win_d       = win_q;
        unique case (state_q)
            StBlank: begin
                if (blank_cnt_q == 4'(BLANK_CYCLES - 1)) state_d = StIdle;
                else                                     blank_cnt_d = blank_cnt_q + 4'd1;
            end
            StIdle: begin
                if (grant != 3'b000) begin
                    state_d = StStep;
                    sub_d   = grant[2];
                    if (grant[2])      units_d = 4'(PENALTY_PTS);
                    else if (grant[1]) units_d = 4'(GIFT_PTS);
                    else               units_d = 4'(DIAMOND_PTS);
                end
            end
            StStep: begin
                units_d = units_q - 4'd1;
                if (sub_q) begin
                    // Floor at 00 drops whatever penalty units remain.
                    if (ones_q == 4'd0 && tens_q == 4'd0) begin
                        state_d = StIdle;
                    end else begin
                        if (ones_q == 4'd0) begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end else begin
                            ones_d = ones_q - 4'd1;
                        end
                        if (units_q == 4'd1 || (tens_q == 4'd0 && ones_q == 4'd1)) state_d = StIdle;
                    end
                end else begin
                    if (ones_q == 4'd9) begin
                        ones_d     = 4'd0;
                        tens_d     = tens_q + 4'd1;
                        level_up_d = 1'b1;
                    end else begin
                        ones_d = ones_q + 4'd1;
                    end
                    if (tens_q == 4'd9 && ones_q == 4'd8) begin
                        win_d   = 1'b1;
                        state_d = StWin;
                    end else if (units_q == 4'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            StWin: ;
            default: state_d = StBlank;
        endcase
    end

    always_comb begin
        score_ones_o = ones_q;
        score_tens_o = tens_q;
        level_up_o   = level_up_q;
        busy_o       = (state_q == StStep);
        win_o        = win_q;
    end

endmodule

// File: tb/tb_score_event_arbiter.sv
// Self-checking bench for score_event_arbiter: directed scenarios plus randomized event batches
// compared against an integer score model.
module tb_score_event_arbiter;

    logic       clk    = 1'b0;
    logic       resetN = 1'b0;
    logic       dia    = 1'b0;
    logic       gift   = 1'b0;
    logic       haz    = 1'b0;
    logic       sof    = 1'b0;
    logic [3:0] ones, tens;
    logic       level_up, busy, win;

    int checks  = 0;
    int passes  = 0;
    int lu_seen = 0;

    score_event_arbiter #(
        .DIAMOND_PTS (1),
        .GIFT_PTS    (5),
        .PENALTY_PTS (3),
        .BLANK_CYCLES(2)
    ) dut (
        .clk             (clk),
        .resetN          (resetN),
        .diamond_hit_i   (dia),
        .gift_hit_i      (gift),
        .hazard_hit_i    (haz),
        .start_of_frame_i(sof),
        .score_ones_o    (ones),
        .score_tens_o    (tens),
        .level_up_o      (level_up),
        .busy_o          (busy),
        .win_o           (win)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (level_up === 1'b1) lu_seen++;

    function automatic int score_now();
        return int'(tens) * 10 + int'(ones);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        {haz, gift, dia} = 3'b000;
        sof = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // New frame, then a one-cycle event pulse; returns at the negedge after the pulse edge.
    task automatic pulse(input logic [2:0] m);
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        {haz, gift, dia} = m;
        @(negedge clk);
        {haz, gift, dia} = 3'b000;
    endtask

    task automatic raw_pulse(input logic [2:0] m);
        @(negedge clk);
        {haz, gift, dia} = m;
        @(negedge clk);
        {haz, gift, dia} = 3'b000;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < 300) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) quiet = 0;
            else               quiet++;
        end
        if (quiet < 4) begin
            checks++;
            $display("FAIL %s_idle_timeout: busy still %b after %0d cycles, want 0", tag, busy, n);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (score_now() !== 0) $display("FAIL reset_score: got %0d want 0", score_now()); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (win !== 1'b0) $display("FAIL reset_win: got %b want 0", win); else passes++;
        checks++; if (level_up !== 1'b0) $display("FAIL reset_level_up: got %b want 0", level_up); else passes++;
    endtask

    task automatic test_blank();
        resetN = 1'b1;
        @(negedge clk);
        dia = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (score_now() !== 0 || busy !== 1'b0)
                $display("FAIL blank_hold[%0d]: score %0d busy %b, want 0 and 0", i, score_now(), busy);
            else passes++;
        end
        dia = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_latency();
        @(negedge clk);
        dia = 1'b1;
        @(negedge clk);
        checks++; if (score_now() !== 0) $display("FAIL lat_e0: got %0d want 0", score_now()); else passes++;
        @(negedge clk);
        checks++; if (score_now() !== 0) $display("FAIL lat_e1: got %0d want 0", score_now()); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL lat_busy: got %b want 1", busy); else passes++;
        @(negedge clk);
        checks++; if (score_now() !== 1) $display("FAIL lat_e2: got %0d want 1", score_now()); else passes++;
        repeat (50) @(negedge clk);
        checks++; if (score_now() !== 1) $display("FAIL held_level: got %0d want 1", score_now()); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL held_busy: got %b want 0", busy); else passes++;
        dia = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_rollover();
        int exp_s[7] = '{8, 9, 10, 11, 12, 13, 13};
        int exp_l[7] = '{0, 0, 1, 0, 0, 0, 0};
        int bcnt = 0;
        for (int i = 0; i < 7; i++) begin
            pulse(3'b001);
            wait_idle("build8");
        end
        checks++; if (score_now() !== 8) $display("FAIL roll_start: got %0d want 8", score_now()); else passes++;
        pulse(3'b010);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (busy === 1'b1) bcnt++;
            checks++;
            if (score_now() !== exp_s[k] || int'(level_up) !== exp_l[k])
                $display("FAIL roll_step[%0d]: score %0d lu %b, want %0d lu %0d",
                         k, score_now(), level_up, exp_s[k], exp_l[k]);
            else passes++;
        end
        checks++; if (bcnt !== 5) $display("FAIL roll_busy_cycles: got %0d want 5", bcnt); else passes++;
    endtask

    task automatic test_simultaneous();
        int exp_t[9] = '{19, 18, 17, 18, 19, 20, 21, 22, 23};
        int trace[$];
        int last, lu0, got;
        pulse(3'b010); wait_idle("build20a");
        pulse(3'b001); wait_idle("build20b");
        pulse(3'b001); wait_idle("build20c");
        checks++; if (score_now() !== 20) $display("FAIL sim_start: got %0d want 20", score_now()); else passes++;
        lu0  = lu_seen;
        last = 20;
        pulse(3'b111);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (score_now() != last) begin
                last = score_now();
                trace.push_back(last);
            end
        end
        for (int i = 0; i < 9; i++) begin
            got = (i < trace.size()) ? trace[i] : -1;
            checks++;
            if (got !== exp_t[i]) $display("FAIL sim_trace[%0d]: got %0d want %0d", i, got, exp_t[i]);
            else passes++;
        end
        checks++; if (trace.size() !== 9) $display("FAIL sim_trace_len: got %0d want 9", trace.size()); else passes++;
        checks++; if (lu_seen - lu0 !== 1) $display("FAIL sim_level_ups: got %0d want 1", lu_seen - lu0); else passes++;
    endtask

    task automatic test_floor();
        int trace[$];
        int last;
        for (int i = 0; i < 7; i++) begin
            pulse(3'b100);
            wait_idle("build2");
        end
        checks++; if (score_now() !== 2) $display("FAIL floor_start: got %0d want 2", score_now()); else passes++;
        last = 2;
        pulse(3'b100);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (score_now() != last) begin
                last = score_now();
                trace.push_back(last);
            end
        end
        checks++;
        if (trace.size() !== 2 || trace[0] !== 1 || trace[1] !== 0)
            $display("FAIL floor_trace: got %p want '{1, 0}", trace);
        else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL floor_busy: got %b want 0", busy); else passes++;
        pulse(3'b100);
        wait_idle("floor0");
        checks++; if (score_now() !== 0) $display("FAIL floor_hold: got %0d want 0", score_now()); else passes++;
    endtask

    task automatic test_random();
        int s = 0;
        int mwin = 0;
        int ns, lu_exp, lu0;
        logic [2:0] m;
        for (int b = 0; b < 30; b++) begin
            m      = 3'($urandom_range(1, 7));
            lu_exp = 0;
            if (mwin == 0) begin
                if (m[2]) s = (s >= 3) ? s - 3 : 0;
                if (m[1]) begin
                    ns = (s + 5 > 99) ? 99 : s + 5;
                    lu_exp += ns / 10 - s / 10;
                    s = ns;
                    if (s == 99) mwin = 1;
                end
                if (m[0] && mwin == 0) begin
                    ns = (s + 1 > 99) ? 99 : s + 1;
                    lu_exp += ns / 10 - s / 10;
                    s = ns;
                    if (s == 99) mwin = 1;
                end
            end
            lu0 = lu_seen;
            pulse(m);
            wait_idle("rand");
            checks++;
            if (score_now() !== s || int'(win) !== mwin || lu_seen - lu0 !== lu_exp)
                $display("FAIL rand[%0d] mask %b: score %0d win %b lu %0d, want %0d win %0d lu %0d",
                         b, m, score_now(), win, lu_seen - lu0, s, mwin, lu_exp);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(3'b010);
        @(negedge clk);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        checks++; if (score_now() !== 0) $display("FAIL midrst_score: got %0d want 0", score_now()); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
        checks++; if (win !== 1'b0) $display("FAIL midrst_win: got %b want 0", win); else passes++;
        @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_frame_gate();
        raw_pulse(3'b001);
        @(negedge clk);
        @(negedge clk);
        raw_pulse(3'b001);
        wait_idle("gate1");
`ifdef SCORE_FRAME_GATE_EN
        checks++; if (score_now() !== 1) $display("FAIL gate_same_frame: got %0d want 1", score_now()); else passes++;
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
        raw_pulse(3'b001);
        wait_idle("gate2");
        checks++; if (score_now() !== 2) $display("FAIL gate_new_frame: got %0d want 2", score_now()); else passes++;
`else
        checks++; if (score_now() !== 2) $display("FAIL ungated_two: got %0d want 2", score_now()); else passes++;
`endif
    endtask

    task automatic test_win();
        int trace[$];
        int last;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            pulse(3'b011);
            wait_idle("build96");
        end
        pulse(3'b001);
        wait_idle("build97");
        checks++; if (score_now() !== 97) $display("FAIL win_start: got %0d want 97", score_now()); else passes++;
        checks++; if (win !== 1'b0) $display("FAIL win_early: got %b want 0", win); else passes++;
        last = 97;
        pulse(3'b010);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (score_now() != last) begin
                last = score_now();
                trace.push_back(last);
            end
        end
        checks++;
        if (trace.size() !== 2 || trace[0] !== 98 || trace[1] !== 99)
            $display("FAIL win_trace: got %p want '{98, 99}", trace);
        else passes++;
        checks++; if (win !== 1'b1) $display("FAIL win_flag: got %b want 1", win); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL win_busy: got %b want 0", busy); else passes++;
        pulse(3'b111);
        wait_idle("after_win");
        checks++; if (score_now() !== 99) $display("FAIL win_sticky_score: got %0d want 99", score_now()); else passes++;
        checks++; if (win !== 1'b1) $display("FAIL win_sticky_flag: got %b want 1", win); else passes++;
    endtask

    initial begin
        test_reset();
        test_blank();
        test_single_latency();
        test_rollover();
        test_simultaneous();
        test_floor();
        test_random();
        test_reset_mid();
        test_frame_gate();
        test_win();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/score_event_arbiter.md
Name: score_event_arbiter

Overview:
- Arbitrates the game's scoring event requesters (diamond pickup, gift pickup, Bumpy hazard hit) onto a single 2-digit BCD score register, sequencing multi-point updates one unit per clock.
- Sits between the collision/hit-detection logic and the seven-segment/score display path.
- Issues a level-up pulse on every tens rollover and latches a win flag at 99.

Parameters:
- DIAMOND_PTS, 1, points added per diamond event (1..9)
- GIFT_PTS, 5, points added per gift event (1..9)
- PENALTY_PTS, 3, points subtracted per hazard event (1..9)
- BLANK_CYCLES, 2, cycles after reset release during which all events are ignored (1..15)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- diamond_hit  in  1  diamond collision level; may stay high for many cycles
- gift_hit  in  1  gift collision level
- hazard_hit  in  1  hazard collision level
- start_of_frame  in  1  one-cycle frame strobe; used only with SCORE_FRAME_GATE_EN
- score_ones  out  4  BCD ones digit
- score_tens  out  4  BCD tens digit
- level_up  out  1  one-cycle pulse when the tens digit increments
- busy  out  1  high while an update is being sequenced
- win  out  1  sticky; high once the score reaches 99

Behaviour:
- Reset is asynchronous, active-low, on clk. On reset:
  - score_ones=0, score_tens=0; level_up=0, busy=0, win=0.
  - All pending bits cleared; edge-detect history registers cleared; FSM enters BLANK with blank counter=0.
- Edge detection: each *_hit input is registered once; an event is its rising edge (cur & ~prev). A held level produces exactly one event.
- Pending bits: one sticky bit per source, set on that source's event. Cleared only when that source is granted.
  - Simultaneous events on different sources all set their bits; none are lost.
  - A repeat event on an already-pending source is merged (no double count).
- FSM states:
  - BLANK: events are discarded and pending bits are held clear. The blank counter counts to BLANK_CYCLES-1, then the FSM goes to IDLE. Edge history still updates, so a level held through blank does not fire.
  - IDLE: if any pending bit is set, grant by fixed priority hazard > gift > diamond. Load the unit counter with that source's points, clear the granted pending bit, and go to STEP. busy goes high in the cycle after the grant.
  - STEP: each cycle applies one BCD unit step, then decrements the unit counter. When the counter reaches 0 after a step, go to IDLE (busy low the following cycle).
  - WIN: entered when the score reaches 99 during STEP. Remaining units are dropped, and all events and pending bits are ignored. Held until reset.
- BCD increment:
  - ones 9 -> 0 with tens+1; level_up pulses for exactly that cycle.
  - At 99 the score saturates, win is set, and the FSM enters WIN.
- BCD decrement:
  - ones 0 -> 9 with tens-1.
  - At 00 the score floors at 00; remaining units are discarded and the FSM goes to IDLE.
- Events arriving during BLANK are ignored. Events arriving during STEP are captured into pending bits and serviced afterward.
- Latency: event edge on input to first score change is 3 cycles (register, pending/grant, step).
- Reset asserted mid-sequence aborts immediately to reset values.

Optional Feature:
- Macro: SCORE_FRAME_GATE_EN.
- Defined:
  - Each source may set its pending bit at most once per frame.
  - A per-source "used" flag is set when the pending bit is set, and cleared by start_of_frame.
  - Events on a source whose used flag is set are discarded.
  - If start_of_frame and an event coincide, the event is accepted and the flag stays set.
- Not defined: start_of_frame is ignored and no gating logic exists.

Test Plan:
- Reset release, diamond_hit high in cycles 1..2 (BLANK_CYCLES=2) and held -> no score change; score stays 00, busy=0.
- Single 1-cycle diamond_hit pulse after blank -> score 01 exactly 3 cycles after the edge; diamond_hit then held 50 cycles -> still 01.
- Score 08, gift_hit pulse (5 pts) -> score steps 09,10,11,12,13 on consecutive cycles; level_up high only in the 09->10 cycle; busy high for 5 cycles.
- diamond, gift and hazard rising in the same cycle at score 20 -> hazard first (17), then gift (22), then diamond (23); final 23.
- Score 02, hazard_hit (3 pts) -> 01, 00, then holds at 00, FSM back to IDLE; score 97 + gift -> 98, 99, win=1; later events leave 99.
- With SCORE_FRAME_GATE_EN: two diamond pulses in one frame -> +1 only; a pulse after start_of_frame -> +1 more.
